// File: rtl/bus_dma.sv
// bus_dma: block-copy bus initiator for the shared 16-bit data / 20-bit address bus.
// Copies `count` words from src_addr.. to dst_addr.., one read cycle then one
// write cycle per word, ascending. Bus use is gated by bus_req/bus_grant so the
// CPU keeps priority; a dropped grant stalls the FSM and releases the bus at once.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               transfer request, sampled only in IDLE
//   src_addr, dst_addr  first source / destination word address (latched on start)
//   count               words to copy (latched on start); 0 goes straight to DONE
//   busy                state != IDLE
//   done                one-cycle completion pulse
//   bus_req             asking for the bus (READ or WRITE)
//   bus_grant           bus owned this cycle
//   bus_addr            tri-state address, driven only while owning the bus
//   bus_data            tri-state data, driven only during an owned write
//   read, write         bus strobes, mutually exclusive
module bus_dma #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [CNT_WIDTH-1:0]  count,
    output logic                  busy,
    output logic                  done,
    output logic                  bus_req,
    input  logic                  bus_grant,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    inout  wire  [DATA_WIDTH-1:0] bus_data,
    output logic                  read,
    output logic                  write
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_src;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [CNT_WIDTH-1:0]  r_idx;
    logic [DATA_WIDTH-1:0] r_data;

    logic [CNT_WIDTH-1:0]  w_idx_nxt;
    logic [ADDR_WIDTH-1:0] w_idx_ext;
    logic                  w_rd_own;
    logic                  w_wr_own;

    assign w_idx_nxt = r_idx + 1'b1;
    // Index is zero-extended (or truncated) to address width; the add then
    // wraps modulo 2^ADDR_WIDTH with no special casing.
    assign w_idx_ext = ADDR_WIDTH'(r_idx);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src   <= src_addr;
                        r_dst   <= dst_addr;
                        r_cnt   <= count;
                        r_idx   <= '0;
                        r_state <= (count != '0) ? S_READ : S_DONE;
                    end
                end
                S_READ: begin
                    // Without grant the memory is not ours; hold and retry.
                    if (bus_grant) begin
                        r_data  <= bus_data;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (bus_grant) begin
                        r_idx   <= w_idx_nxt;
                        // Compare the incremented index so count = 2^CNT_WIDTH-1
                        // terminates before the index could wrap.
                        r_state <= (w_idx_nxt == r_cnt) ? S_DONE : S_READ;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign bus_req = (r_state == S_READ) || (r_state == S_WRITE);

    // Bus drive is combinational in grant so a grant drop (or async reset,
    // which clears the state) releases the bus within the same cycle.
    assign w_rd_own = (r_state == S_READ)  && bus_grant;
    assign w_wr_own = (r_state == S_WRITE) && bus_grant;
    assign read     = w_rd_own;
    assign write    = w_wr_own;

    assign bus_addr = w_rd_own ? (r_src + w_idx_ext) :
                      w_wr_own ? (r_dst + w_idx_ext) : 'z;
    assign bus_data = w_wr_own ? r_data : 'z;

endmodule

// File: tb/tb_bus_dma.sv
`timescale 1ns/1ps
module tb_bus_dma;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          bus_grant = 1'b1;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [CW-1:0] count = '0;
    wire           busy, done, bus_req, read, write;
    wire  [AW-1:0] bus_addr;
    wire  [DW-1:0] bus_data;

    always #5 clk = ~clk;

    bus_dma #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .count(count),
        .busy(busy), .done(done), .bus_req(bus_req), .bus_grant(bus_grant),
        .bus_addr(bus_addr), .bus_data(bus_data), .read(read), .write(write)
    );

    // Memory model: 4K words decoded on address bits [11:0], asynchronous read.
    logic [DW-1:0] mem [0:4095];
    logic          pl_en = 1'b0;
    logic [11:0]   pl_a = '0;
    logic [DW-1:0] pl_d = '0;

    always @(posedge clk) begin
        if (write)      mem[bus_addr[11:0]] <= bus_data;
        else if (pl_en) mem[pl_a] <= pl_d;
    end
    assign bus_data = read ? mem[bus_addr[11:0]] : 'z;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic [AW-1:0] rq[$];
    wr_t           wq[$];
    int            dq[$];
    int            total = 0;
    int            bad = 0;
    int            done_cnt = 0;

    task automatic chk(input string nm, input bit ok, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every strobe / done the DUT presents.
    initial begin
        logic [AW-1:0] ea;
        wr_t           ew;
        int            ec;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (read && write) chk("rw_exclusive", 1'b0, {read, write}, 0);
                if (read) begin
                    if (rq.size() == 0) chk("read_unexpected", 1'b0, bus_addr, 0);
                    else begin
                        ea = rq.pop_front();
                        chk("read_addr", bus_addr === ea, bus_addr, ea);
                    end
                end
                if (write) begin
                    if (wq.size() == 0) chk("write_unexpected", 1'b0, bus_addr, 0);
                    else begin
                        ew = wq.pop_front();
                        chk("write_addr", bus_addr === ew.a, bus_addr, ew.a);
                        chk("write_data", bus_data === ew.d, bus_data, ew.d);
                    end
                end
                if (done) begin
                    done_cnt++;
                    chk("busy_with_done", busy === 1'b1, busy, 1);
                    if (dq.size() == 0) chk("done_unexpected", 1'b0, cyc, 0);
                    else begin
                        ec = dq.pop_front();
                        chk("done_cycle", cyc == ec, cyc, ec);
                    end
                end
            end
        end
    end

    task automatic preload(input logic [11:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issue a start and push the expected traffic: nrd reads, nwr writes and
    // (optionally) a done at start_edge + 2N + stall cycles.
    task automatic issue(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n,
                         input logic [2:0][DW-1:0] v, input int nrd, input int nwr,
                         input bit exp_done, input int stall);
        wr_t w;
        int  s_edge;
        for (int i = 0; i < nrd; i++) rq.push_back(s + AW'(i));
        for (int i = 0; i < nwr; i++) begin
            w.a = d + AW'(i);
            w.d = v[i];
            wq.push_back(w);
        end
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; count = CW'(n);
        @(posedge clk);
        #1;
        s_edge = cyc;
        start = 1'b0;
        if (exp_done) dq.push_back(s_edge + 2 * n + stall);
    endtask

    task automatic wait_done(input int lim);
        int n0;
        int k;
        n0 = done_cnt;
        k = 0;
        while (done_cnt == n0 && k < lim) begin
            @(negedge clk);
            #1;
            k++;
            chk("busy_during", busy === 1'b1, busy, 1);
        end
        chk("done_timeout", done_cnt != n0, k, lim);
        @(negedge clk);
        #1;
        chk("busy_after_done", busy === 1'b0, busy, 0);
        chk("done_one_cycle", done === 1'b0, done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy === 1'b0, busy, 0);
        chk("rst_done", done === 1'b0, done, 0);
        chk("rst_req", bus_req === 1'b0, bus_req, 0);
        chk("rst_read", read === 1'b0, read, 0);
        chk("rst_write", write === 1'b0, write, 0);
        reset = 1'b0;

        // Basic copy
        preload(12'h010, 16'h1111); preload(12'h011, 16'h2222); preload(12'h012, 16'h3333);
        preload(12'h100, 16'h0000); preload(12'h101, 16'h0000); preload(12'h102, 16'h0000);
        issue(20'h00010, 20'h00100, 3, {16'h3333, 16'h2222, 16'h1111}, 3, 3, 1'b1, 0);
        wait_done(40);
        chk("basic_m0", mem[12'h100] === 16'h1111, mem[12'h100], 16'h1111);
        chk("basic_m1", mem[12'h101] === 16'h2222, mem[12'h101], 16'h2222);
        chk("basic_m2", mem[12'h102] === 16'h3333, mem[12'h102], 16'h3333);

        // Zero count: no strobes, address bus never shows the source
        issue(20'h00040, 20'h00300, 0, '0, 0, 0, 1'b1, 0);
        chk("zero_req", bus_req === 1'b0, bus_req, 0);
        chk("zero_addr_rel", bus_addr !== 20'h00040, bus_addr, 20'h00040);
        wait_done(10);

        // Grant stall in WRITE of word 1
        preload(12'h020, 16'hAAAA); preload(12'h021, 16'hBBBB); preload(12'h022, 16'hCCCC);
        issue(20'h00020, 20'h00110, 3, {16'hCCCC, 16'hBBBB, 16'hAAAA}, 3, 3, 1'b1, 4);
        repeat (3) @(posedge clk);
        #1;
        bus_grant = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("stall_write", write === 1'b0, write, 0);
            chk("stall_read", read === 1'b0, read, 0);
            chk("stall_req", bus_req === 1'b1, bus_req, 1);
            chk("stall_addr_rel", bus_addr !== 20'h00111, bus_addr, 20'h00111);
            chk("stall_data_rel", bus_data !== 16'hBBBB, bus_data, 16'hBBBB);
        end
        @(posedge clk);
        #1;
        bus_grant = 1'b1;
        wait_done(40);
        chk("stall_m1", mem[12'h111] === 16'hBBBB, mem[12'h111], 16'hBBBB);
        chk("stall_m2", mem[12'h112] === 16'hCCCC, mem[12'h112], 16'hCCCC);

        // Address wrap: reads at FFFFE, FFFFF, 00000
        preload(12'hFFE, 16'h0A0A); preload(12'hFFF, 16'h0B0B); preload(12'h000, 16'h0C0C);
        issue(20'hFFFFE, 20'h00200, 3, {16'h0C0C, 16'h0B0B, 16'h0A0A}, 3, 3, 1'b1, 0);
        wait_done(40);
        chk("wrap_m2", mem[12'h202] === 16'h0C0C, mem[12'h202], 16'h0C0C);

        // Mid-transfer reset during READ of word 2
        preload(12'h030, 16'h1234); preload(12'h031, 16'h5678); preload(12'h032, 16'h9ABC);
        preload(12'h130, 16'hDEAD); preload(12'h131, 16'hDEAD); preload(12'h132, 16'hDEAD);
        issue(20'h00030, 20'h00130, 3, {16'h9ABC, 16'h5678, 16'h1234}, 3, 2, 1'b0, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mrst_read", read === 1'b0, read, 0);
        chk("mrst_addr_rel", bus_addr !== 20'h00032, bus_addr, 20'h00032);
        chk("mrst_busy", busy === 1'b0, busy, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("mrst_m0", mem[12'h130] === 16'h1234, mem[12'h130], 16'h1234);
        chk("mrst_m1", mem[12'h131] === 16'h5678, mem[12'h131], 16'h5678);
        chk("mrst_m2", mem[12'h132] === 16'hDEAD, mem[12'h132], 16'hDEAD);

        // Start while busy is ignored
        preload(12'h040, 16'h4444); preload(12'h041, 16'h5555);
        preload(12'h050, 16'h7777); preload(12'h150, 16'hDEAD);
        issue(20'h00040, 20'h00140, 2, {16'h0000, 16'h5555, 16'h4444}, 2, 2, 1'b1, 0);
        @(negedge clk);
        start = 1'b1; src_addr = 20'h00050; dst_addr = 20'h00150; count = 16'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(40);
        repeat (5) @(negedge clk);
        chk("busy_ign_m1", mem[12'h141] === 16'h5555, mem[12'h141], 16'h5555);
        chk("busy_ign_new", mem[12'h150] === 16'hDEAD, mem[12'h150], 16'hDEAD);

        chk("queues_empty", rq.size() == 0 && wq.size() == 0 && dq.size() == 0,
            rq.size() + wq.size() + dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
